mem_dados_param: RTL and testbench
==================================

Name: mem_dados_param

Overview:
- Parametrised data memory for the single-cycle/multicycle processor datapath; successor to the fixed 64x32 data memory.
- Adds:
  - configurable width and depth
  - byte-enable writes
  - registered read with valid flag
  - hardware zero-initialisation after reset
  - address range checking
  - end-of-program detection that captures the PC once and then blocks writes

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; any value >= 2.
- ADDR_W, 32, width of the word-address input.
- PC_W, 32, width of the PC inputs and the saved-PC output.
- HALT_PC, 616, program-end threshold; halt triggers when pc_atual > HALT_PC.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_write  in  1  write request.
- mem_read  in  1  read request.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- byte_en  in  DATA_W/8  per-byte write enable; bit i covers wdata[8i+7:8i].
- rdata  out  DATA_W  read data.
- rdata_valid  out  1  rdata holds the result of the previous cycle's read.
- ready  out  1  memory initialised and accepting requests.
- addr_err  out  1  previous-cycle request addressed a word >= DEPTH.
- pc_atual  in  PC_W  current PC, used for the threshold check.
- end_atual  in  PC_W  PC value to capture on halt.
- final_prog  in  1  explicit end-of-program strobe.
- pc_saved  out  PC_W  captured PC.
- halted  out  1  program has ended.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs go to: rdata=0, rdata_valid=0, ready=0, addr_err=0, pc_saved=0, halted=0.
  - State goes to INIT with the clear counter at 0.
  - Applies at any time, including mid-INIT or mid-HALT; the clear restarts from word 0.
- State machine, three states:
  - INIT:
    - Each cycle writes 0 to word[cnt], then cnt+1.
    - After writing word DEPTH-1, moves to RUN; ready=1 from the first RUN cycle. The clear takes exactly DEPTH cycles.
    - All requests are ignored: no write, rdata_valid stays 0, addr_err stays 0.
    - final_prog and the PC threshold are ignored.
  - RUN:
    - Normal operation.
    - Moves to HALT at the clock edge where final_prog=1 or pc_atual > HALT_PC (unsigned compare).
    - On that edge pc_saved <= end_atual and halted <= 1.
    - A write presented on the same edge still completes.
  - HALT:
    - pc_saved and halted are held; no further capture.
    - Writes are suppressed; reads still work.
    - Exit only via rst_n.
- Write, in RUN and when addr < DEPTH:
  - On the rising edge, each byte with byte_en[i]=1 is updated; other bytes are retained.
  - byte_en=0 performs no write.
- Read, in RUN or HALT:
  - When mem_read=1 at edge N, rdata shows word[addr] after edge N with rdata_valid=1 for that one cycle. Latency is 1 cycle; back-to-back reads are allowed every cycle.
  - When mem_read=0, rdata_valid=0 and rdata holds its last value.
- Same-address read and write on the same edge: rdata returns the old data (read-before-write).
- Out of range (addr >= DEPTH):
  - The write is suppressed.
  - A read returns rdata=0 with rdata_valid=1.
  - addr_err=1 for one cycle after the edge; it is otherwise 0.
  - addr_err is only flagged when mem_read or mem_write is high.
- mem_read and mem_write both high is legal; both are executed under the rules above.

Test Plan:
- Reset, then count cycles while polling ready -> ready rises after exactly 64 clocks. Reading words 0, 31 and 63 then gives rdata=0 with rdata_valid=1 one cycle after each request.
- Write addr=5, wdata=0xDEADBEEF, byte_en=4'b1111, then write addr=5, wdata=0x00000011, byte_en=4'b0001, then read 5 -> rdata=0xDEADBE11.
- Read and write addr=7 on the same edge (old value 0, wdata=0x12345678) -> rdata=0. A following read returns 0x12345678.
- Write addr=64, wdata=0xFFFFFFFF -> addr_err=1 for one cycle and no array word changes. Read addr=64 -> rdata=0, rdata_valid=1, addr_err=1.
- Hold end_atual=0x100; raise pc_atual from 616 to 617 -> halted=1 and pc_saved=0x100 after that edge. Then pulse final_prog with end_atual=0x200 -> pc_saved stays 0x100. Then write addr=3 -> no change; reading 3 still returns its earlier value.
- Pulse rst_n low during INIT (cycle 20) and again in HALT -> all outputs are 0 immediately. The clear restarts, ready rises 64 cycles after release, and halted=0.

Source files
------------

// File: rtl/mem_dados_param_if.sv
// Request/response bundle between the datapath and the data memory.
//
// Handshake: the memory samples a request (mem_read and/or mem_write with
// addr/wdata/byte_en) on every rising clock edge while ready=1; there is no
// back-pressure once ready is high. A read answers exactly one cycle later
// with rdata_valid=1 for that single cycle. Requests presented while ready=0
// are dropped.
interface mem_dados_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PC_W   = 32
);
  logic                  mem_write;
  logic                  mem_read;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     rdata;
  logic                  rdata_valid;
  logic                  ready;
  logic                  addr_err;
  logic [PC_W-1:0]       pc_atual;
  logic [PC_W-1:0]       end_atual;
  logic                  final_prog;
  logic [PC_W-1:0]       pc_saved;
  logic                  halted;
  logic [1:0]            dbg_state;

  modport master (
    output mem_write, mem_read, addr, wdata, byte_en,
    output pc_atual, end_atual, final_prog,
    input  rdata, rdata_valid, ready, addr_err, pc_saved, halted, dbg_state
  );

  modport slave (
    input  mem_write, mem_read, addr, wdata, byte_en,
    input  pc_atual, end_atual, final_prog,
    output rdata, rdata_valid, ready, addr_err, pc_saved, halted, dbg_state
  );
endinterface

// File: rtl/mem_dados_param.sv
// Parametrised data memory: self-clearing after reset, byte-enable writes,
// registered reads, range checking and one-shot end-of-program capture.
module mem_dados_param #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 32,
  parameter int PC_W    = 32,
  parameter int HALT_PC = 616
) (
  input  logic clk,
  input  logic rst_n,
  mem_dados_param_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH);

  // INIT clears the array, RUN serves requests, HALT freezes writes and the
  // captured PC until the next reset. Encoding is visible on dbg_state.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0]    pc_saved_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               rdata_valid_q;
  logic               addr_err_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               addr_ok;
  logic [CNT_W-1:0]   idx;
  logic               active;
  logic               halt_req;
  logic               wr_en;
  logic               rd_en;

  // Request decode shared by the array, the read path and the FSM.
  always_comb begin
    addr_ok  = (64'(bus.addr) < 64'(DEPTH));
    idx      = bus.addr[CNT_W-1:0];
    active   = (state_q != ST_INIT);
    halt_req = bus.final_prog || (bus.pc_atual > PC_W'(HALT_PC));
    wr_en    = (state_q == ST_RUN) && bus.mem_write && addr_ok;
    rd_en    = active && bus.mem_read;
  end

  // State, clear counter and captured PC; the capture happens only on the
  // RUN->HALT edge so later strobes cannot overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      pc_saved_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_RUN && halt_req) pc_saved_q <= bus.end_atual;
    end
  end

  // Next state: INIT walks every word once, RUN watches for program end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:  if (halt_req) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    bus.ready     = (state_q != ST_INIT);
    bus.halted    = (state_q == ST_HALT);
    bus.dbg_state = state_q;
    bus.pc_saved  = pc_saved_q;
  end

  // Storage array: zero fill during INIT, byte-masked writes in RUN.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.byte_en[i]) mem_q[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Registered read port; reads sample the array before this edge's write,
  // giving read-before-write on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      rdata_valid_q <= rd_en;
      if (rd_en) rdata_q <= addr_ok ? mem_q[idx] : '0;
      addr_err_q    <= active && (bus.mem_read || bus.mem_write) && !addr_ok;
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.addr_err    = addr_err_q;

endmodule

// File: tb/tb_mem_dados_param.sv
// Directed bench for mem_dados_param with hand-computed expectations.
module tb_mem_dados_param;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   n;

  mem_dados_param_if #(.DATA_W(32), .ADDR_W(32), .PC_W(32)) bus ();

  mem_dados_param #(
    .DATA_W(32), .DEPTH(64), .ADDR_W(32), .PC_W(32), .HALT_PC(616)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.byte_en    = '0;
    bus.final_prog = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cnt++;
      if (bus.ready) break;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.mem_write = 1'b1;
    bus.addr      = a;
    bus.wdata     = d;
    bus.byte_en   = be;
    tick();
    bus.mem_write = 1'b0;
    bus.byte_en   = '0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.mem_read = 1'b1;
    bus.addr     = a;
    tick();
    bus.mem_read = 1'b0;
    chk({tag, "_valid"}, 64'(bus.rdata_valid), 64'd1);
    chk({tag, "_data"}, 64'(bus.rdata), 64'(exp));
  endtask

  // stimulus and scoring
  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    bus.pc_atual  = '0;
    bus.end_atual = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_valid", 64'(bus.rdata_valid), 64'd0);
    chk("rst_addr_err", 64'(bus.addr_err), 64'd0);
    chk("rst_pc_saved", 64'(bus.pc_saved), 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("init_cycles", 64'(n), 64'd64);

    // cleared words
    do_read("rd0", 32'd0, 32'h0);
    do_read("rd31", 32'd31, 32'h0);
    do_read("rd63", 32'd63, 32'h0);
    tick();
    chk("idle_valid", 64'(bus.rdata_valid), 64'd0);

    // byte enables
    do_write(32'd5, 32'hDEADBEEF, 4'b1111);
    do_write(32'd5, 32'h00000011, 4'b0001);
    do_read("be_low", 32'd5, 32'hDEADBE11);
    do_write(32'd9, 32'hAABBCCDD, 4'b1111);
    do_write(32'd9, 32'h11223344, 4'b0110);
    do_write(32'd9, 32'h55555555, 4'b0000);
    do_read("be_mid", 32'd9, 32'hAA2233DD);
    tick();
    chk("hold_data", 64'(bus.rdata), 64'hAA2233DD);
    chk("hold_valid", 64'(bus.rdata_valid), 64'd0);

    // same-edge read and write: old data returned
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    bus.addr      = 32'd7;
    bus.wdata     = 32'h12345678;
    bus.byte_en   = 4'hF;
    tick();
    idle_inputs();
    chk("rbw_old", 64'(bus.rdata), 64'h0);
    chk("rbw_valid", 64'(bus.rdata_valid), 64'd1);
    do_read("rbw_new", 32'd7, 32'h12345678);

    // out of range
    do_write(32'd64, 32'hFFFFFFFF, 4'hF);
    chk("oor_wr_err", 64'(bus.addr_err), 64'd1);
    tick();
    chk("oor_err_clear", 64'(bus.addr_err), 64'd0);
    do_read("oor_alias0", 32'd0, 32'h0);
    do_read("pre_oor", 32'd5, 32'hDEADBE11);
    do_read("oor_rd", 32'd64, 32'h0);
    chk("oor_rd_err", 64'(bus.addr_err), 64'd1);
    bus.addr = 32'd100;
    tick();
    chk("oor_no_req", 64'(bus.addr_err), 64'd0);
    do_read("inrange_err", 32'd63, 32'h0);
    chk("inrange_err_flag", 64'(bus.addr_err), 64'd0);

    // halt by PC threshold; write on the halting edge still lands
    do_write(32'd3, 32'hCAFEF00D, 4'hF);
    bus.end_atual = 32'h100;
    bus.pc_atual  = 32'd616;
    tick();
    chk("pc616_halted", 64'(bus.halted), 64'd0);
    bus.pc_atual = 32'd617;
    do_write(32'd4, 32'h00000044, 4'hF);
    chk("halt_flag", 64'(bus.halted), 64'd1);
    chk("halt_pc", 64'(bus.pc_saved), 64'h100);
    bus.pc_atual   = '0;
    bus.end_atual  = 32'h200;
    bus.final_prog = 1'b1;
    tick();
    bus.final_prog = 1'b0;
    chk("halt_pc_hold", 64'(bus.pc_saved), 64'h100);
    chk("halt_hold", 64'(bus.halted), 64'd1);
    do_write(32'd3, 32'h00000000, 4'hF);
    do_read("halt_wr_blocked", 32'd3, 32'hCAFEF00D);
    do_read("halt_edge_wr", 32'd4, 32'h00000044);

    // reset while halted, right after a valid read
    #2;
    rst_n = 1'b0;
    #1;
    chk("hrst_halted", 64'(bus.halted), 64'd0);
    chk("hrst_pc", 64'(bus.pc_saved), 64'd0);
    chk("hrst_ready", 64'(bus.ready), 64'd0);
    chk("hrst_rdata", 64'(bus.rdata), 64'd0);
    chk("hrst_valid", 64'(bus.rdata_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("hrst_init_cycles", 64'(n), 64'd64);
    chk("hrst_halted_after", 64'(bus.halted), 64'd0);
    do_read("hrst_cleared", 32'd3, 32'h0);

    // reset in the middle of INIT restarts the clear
    do_write(32'd0, 32'h0BADF00D, 4'hF);
    do_write(32'd40, 32'h40404040, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_read = 1'b1;
    bus.addr     = 32'd40;
    for (int i = 0; i < 20; i++) tick();
    chk("init_rd_ignored", 64'(bus.rdata_valid), 64'd0);
    chk("init_ready_low", 64'(bus.ready), 64'd0);
    bus.mem_read = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("irst_ready", 64'(bus.ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("irst_init_cycles", 64'(n), 64'd64);
    do_read("irst_w0", 32'd0, 32'h0);
    do_read("irst_w40", 32'd40, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
